// File: rtl/dac_ramp_interp.sv
// dac_ramp_interp: linear ramp generator feeding a DAC.
// A transfer on DATA_IN/VALID_IN starts a ramp of N = 2^LOG2_STEPS cycles.
// The ramp runs from the current DATA_OUT to the new target. A fixed-point
// accumulator (integer part = DATA_OUT, LOG2_STEPS fraction bits, one guard
// bit) adds the signed delta once per cycle. On the last step the accumulator
// is loaded with the exact target, so the ramp lands precisely on it.
//
// Optional feature (macro RAMP_RETARGET_EN): READY stays high during a ramp.
// A new target then restarts the ramp from the current DATA_OUT.
//
// Ports:
//   CLK       sole clock, rising edge
//   RST       asynchronous active-high reset
//   DATA_IN   signed ramp target
//   VALID_IN  DATA_IN valid; transfer when VALID_IN & READY on a rising edge
//   READY     block can accept a target
//   DATA_OUT  registered signed DAC sample
//   BUSY      ramp in progress
//   DONE      one-cycle pulse when a ramp completes
module dac_ramp_interp #(
  parameter int unsigned DAC_WIDTH  = 12,
  parameter int unsigned LOG2_STEPS = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DAC_WIDTH-1:0] DATA_IN,
  input  logic                 VALID_IN,
  output logic                 READY,
  output logic [DAC_WIDTH-1:0] DATA_OUT,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned ACC_W = DAC_WIDTH + LOG2_STEPS + 1;
  localparam int unsigned DLT_W = DAC_WIDTH + 1;
  localparam int unsigned CNT_W = LOG2_STEPS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t               state_q,  state_d;
  logic [ACC_W-1:0]     acc_q,    acc_d;
  logic [DLT_W-1:0]     delta_q,  delta_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [DAC_WIDTH-1:0] target_q, target_d;
  logic                 done_q,   done_d;
  logic                 busy_q,   busy_d;
  logic                 ready_q,  ready_d;

  logic                 xfer_c;
  logic                 last_c;
  logic                 retarget_c;
  logic [DLT_W-1:0]     delta_new_c;
  logic [ACC_W-1:0]     delta_ext_c;
  logic [ACC_W-1:0]     target_acc_c;
  logic [ACC_W-1:0]     out_acc_c;
  logic                 unused_guard;

  // Integer part of the accumulator is the DAC sample (floor of the fraction).
  assign DATA_OUT = acc_q[LOG2_STEPS+DAC_WIDTH-1:LOG2_STEPS];
  assign READY    = ready_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

  // Guard bit only absorbs the sign of intermediate sums; it is never output.
  assign unused_guard = acc_q[ACC_W-1];

  assign xfer_c = VALID_IN & ready_q;
  assign last_c = (cnt_q == {CNT_W{1'b1}});

`ifdef RAMP_RETARGET_EN
  assign retarget_c = xfer_c;
`else
  assign retarget_c = 1'b0;
`endif

  // One extra bit keeps the full-scale delta (e.g. -2048 -> +2047) exact.
  assign delta_new_c  = DLT_W'($signed(DATA_IN)) - DLT_W'($signed(DATA_OUT));
  assign delta_ext_c  = ACC_W'($signed(delta_q));
  assign target_acc_c = ACC_W'($signed(target_q)) << LOG2_STEPS;
  assign out_acc_c    = ACC_W'($signed(DATA_OUT)) << LOG2_STEPS;

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      delta_q  <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      delta_q  <= delta_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    delta_d  = delta_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer_c) begin
          delta_d  = delta_new_c;
          cnt_d    = '0;
          target_d = DATA_IN;
          state_d  = ST_RAMP;
        end
      end
      ST_RAMP: begin
        // A retarget wins over completion, even on the final step.
        if (retarget_c) begin
          acc_d    = out_acc_c;
          delta_d  = delta_new_c;
          cnt_d    = '0;
          target_d = DATA_IN;
        end else if (last_c) begin
          acc_d   = target_acc_c;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_q + delta_ext_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RAMP);
`ifdef RAMP_RETARGET_EN
    ready_d = 1'b1;
`else
    ready_d = (state_d == ST_IDLE);
`endif
  end

endmodule

// File: tb/tb_dac_ramp_interp.sv
// Directed bench for dac_ramp_interp (default build, DAC_WIDTH=12, N=1024).
module tb_dac_ramp_interp;

  localparam int DW = 12;
  localparam int L  = 10;
  localparam int N  = 1024;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] DATA_IN;
  logic          VALID_IN;
  logic          READY;
  logic [DW-1:0] DATA_OUT;
  logic          BUSY;
  logic          DONE;

  int n_checks = 0;
  int n_pass   = 0;

  // Samples captured during the most recent ramp.
  int s_step1;
  int s_step512;
  int busy_cycles;
  int mono_bad;
  int range_bad;

  dac_ramp_interp #(.DAC_WIDTH(DW), .LOG2_STEPS(L)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DATA_IN  (DATA_IN),
    .VALID_IN (VALID_IN),
    .READY    (READY),
    .DATA_OUT (DATA_OUT),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int dout();
    return int'($signed(DATA_OUT));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start a ramp to tgt; optionally assert VALID_IN with poke_val before step poke_step.
  task automatic do_ramp(input int tgt, input int poke_step, input int poke_val);
    int start;
    int expv;
    int prev;
    int cur;
    int lo;
    int hi;
    start       = dout();
    prev        = start;
    lo          = (start < tgt) ? start : tgt;
    hi          = (start < tgt) ? tgt : start;
    busy_cycles = 0;
    mono_bad    = 0;
    range_bad   = 0;
    s_step1     = 0;
    s_step512   = 0;
    check("ready_before", int'(READY), 1);
    DATA_IN  = DW'(tgt);
    VALID_IN = 1'b1;
    tick();
    VALID_IN = 1'b0;
    DATA_IN  = 12'hABC;
    check("xfer_busy",  int'(BUSY), 1);
    check("xfer_ready", int'(READY), 0);
    check("xfer_hold",  dout(), start);
    check("xfer_done",  int'(DONE), 0);
    if (BUSY) busy_cycles++;
    for (int i = 1; i <= N; i++) begin
      if (i == poke_step) begin
        check("poke_ready", int'(READY), 0);
        DATA_IN  = DW'(poke_val);
        VALID_IN = 1'b1;
      end
      tick();
      VALID_IN = 1'b0;
      cur  = dout();
      expv = (start * N + i * (tgt - start)) >>> L;
      check("ramp_data", cur, expv);
      check("ramp_busy", int'(BUSY), int'(i < N));
      check("ramp_done", int'(DONE), int'(i == N));
      if (BUSY) busy_cycles++;
      if ((tgt >= start && cur < prev) || (tgt < start && cur > prev)) mono_bad++;
      if (cur < lo || cur > hi) range_bad++;
      if (i == 1)   s_step1   = cur;
      if (i == 512) s_step512 = cur;
      prev = cur;
    end
    check("ready_after", int'(READY), 1);
    check("busy_cycles", busy_cycles, N);
    check("monotonic",   mono_bad, 0);
    check("in_range",    range_bad, 0);
  endtask

  initial begin
    RST      = 1'b0;
    VALID_IN = 1'b0;
    DATA_IN  = '0;

    // Asynchronous reset in the middle of a clock period.
    #7 RST = 1'b1;
    #1;
    check("rst_data",  dout(), 0);
    check("rst_ready", int'(READY), 1);
    check("rst_busy",  int'(BUSY), 0);
    check("rst_done",  int'(DONE), 0);
    #4 RST = 1'b0;
    tick();
    check("idle_data", dout(), 0);

    // 0 -> 0x3FF with hand-computed intermediate points.
    do_ramp(1023, 0, 0);
    check("up_step1",   s_step1, 0);
    check("up_step512", s_step512, 511);
    check("up_final",   dout(), 1023);

    // 0x3FF -> 0xC00 (-1024), descending.
    do_ramp(-1024, 0, 0);
    check("down_final", dout(), -1024);

    // 0xC00 -> 0x800 (-2048), then full-scale 0x800 -> 0x7FF.
    do_ramp(-2048, 0, 0);
    check("neg_fs", dout(), -2048);
    do_ramp(2047, 0, 0);
    check("fs_final", dout(), 2047);

    // Same target: constant output, full duration.
    do_ramp(2047, 0, 0);
    check("same_final", dout(), 2047);

    // VALID_IN with 0x100 at step 300 is ignored.
    do_ramp(0, 300, 256);
    check("poke_final", dout(), 0);
    check("poke_ready_idle", int'(READY), 1);

    // Reset at step 300 aborts the ramp with no DONE.
    DATA_IN  = 12'h123;
    VALID_IN = 1'b1;
    tick();
    VALID_IN = 1'b0;
    repeat (300) tick();
    check("pre_abort_busy", int'(BUSY), 1);
    #3 RST = 1'b1;
    #1;
    check("abort_data",  dout(), 0);
    check("abort_ready", int'(READY), 1);
    check("abort_busy",  int'(BUSY), 0);
    check("abort_done",  int'(DONE), 0);
    #2 RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_abort_done", int'(DONE), 0);
      check("post_abort_data", dout(), 0);
    end

    // Normal ramp after the abort.
    do_ramp(512, 0, 0);
    check("after_abort_final", dout(), 512);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
